// File: rtl/cdf_pkg.sv
// Purpose : shared types and default sizing for the histogram-to-CDF sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package cdf_pkg;

    localparam int DATA_W       = 20;
    localparam int ADDR_W       = 8;
    localparam int BINS         = 256;
    // Pixel count of one frame; downstream equaliser divides by FRAME_PIXELS - cdf_min.
    localparam int FRAME_PIXELS = 307200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cdf_accum.sv
// Purpose : saturating running sum of histogram bins plus capture of the first nonzero sum.
// Latency : sum updates on the edge that samples en; first_nz follows on the same edge.
// Backpressure: none; every en cycle is consumed.
//
// Ports:
//   clock, reset_n   - clock and synchronous active-low reset
//   clr              - clears sum and the first-nonzero capture (start of a run)
//   en, din          - add din into the running sum this cycle
//   sum              - registered running sum (saturates at all-ones, never wraps)
//   first_nz         - registered first nonzero value of sum since the last clr (0 if none)
module cdf_accum #(
    parameter int DATA_W = cdf_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum,
    output logic [DATA_W-1:0] first_nz
);
    import cdf_pkg::*;

    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] sum_next;
    logic              found;

    // One extra bit catches the carry; on carry the sum pins at all-ones.
    always_comb begin
        wide     = {1'b0, sum} + {1'b0, din};
        sum_next = wide[DATA_W] ? {DATA_W{1'b1}} : wide[DATA_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sum      <= '0;
            first_nz <= '0;
            found    <= 1'b0;
        end else if (clr) begin
            sum      <= '0;
            first_nz <= '0;
            found    <= 1'b0;
        end else if (en) begin
            sum <= sum_next;
            if (!found && (sum_next != '0)) begin
                found    <= 1'b1;
                first_nz <= sum_next;
            end
        end
    end

endmodule

// File: rtl/cdf_sequencer.sv
// Purpose : sweeps a histogram bank once per start and writes its CDF plus cdf_min.
// Latency : read k issued in cycle k+1, CDF[k] written in cycle k+3, cdf_valid in cycle BINS+3.
// Backpressure: none; start is ignored while a run is in progress.
//
// Ports:
//   clock, reset_n             - clock and synchronous active-low reset
//   start, bank_sel            - run request and ping-pong bank, both sampled in IDLE only
//   hist_bank, cdf_bank        - latched bank select for both memories
//   hist_rd_en, hist_addr      - histogram read request (data returns one cycle later)
//   hist_rd_data               - histogram read data
//   cdf_wr_en/addr/wr_data     - CDF memory write port
//   cdf_min, cdf_valid         - first nonzero CDF value, held until next run's cdf_valid pulse
//   busy                       - run in progress
//   hist_wr_en, hist_wr_addr   - only with CDF_HIST_CLEAR_EN: zeroes bin k in cycle k+2
module cdf_sequencer #(
    parameter int DATA_W = cdf_pkg::DATA_W,
    parameter int ADDR_W = cdf_pkg::ADDR_W,
    parameter int BINS   = cdf_pkg::BINS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              bank_sel,
    output logic              hist_bank,
    output logic              cdf_bank,
    output logic              hist_rd_en,
    output logic [ADDR_W-1:0] hist_addr,
    input  logic [DATA_W-1:0] hist_rd_data,
    output logic              cdf_wr_en,
    output logic [ADDR_W-1:0] cdf_addr,
    output logic [DATA_W-1:0] cdf_wr_data,
    output logic [DATA_W-1:0] cdf_min,
    output logic              cdf_valid,
`ifdef CDF_HIST_CLEAR_EN
    output logic              hist_wr_en,
    output logic [ADDR_W-1:0] hist_wr_addr,
`endif
    output logic              busy
);
    import cdf_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BINS - 1);

    state_t            state;
    logic              accept;
    // rd_pend/rd_addr_d mark the cycle in which hist_rd_data is valid and which bin it is.
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [DATA_W-1:0] acc_sum;
    logic [DATA_W-1:0] acc_first_nz;

    assign accept = (state == IDLE) && start;

    cdf_accum #(
        .DATA_W (DATA_W)
    ) u_accum (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr      (accept),
        .en       (rd_pend),
        .din      (hist_rd_data),
        .sum      (acc_sum),
        .first_nz (acc_first_nz)
    );

    // The accumulator register is the write data: it updates on the same edge
    // that raises cdf_wr_en for that bin.
    assign cdf_wr_data = acc_sum;

`ifdef CDF_HIST_CLEAR_EN
    // Clearing a bin on the cycle its data returns means the read has already happened.
    assign hist_wr_en   = rd_pend;
    assign hist_wr_addr = rd_addr_d;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            hist_bank  <= 1'b0;
            cdf_bank   <= 1'b0;
            hist_rd_en <= 1'b0;
            hist_addr  <= '0;
            rd_pend    <= 1'b0;
            rd_addr_d  <= '0;
            cdf_wr_en  <= 1'b0;
            cdf_addr   <= '0;
            cdf_valid  <= 1'b0;
            cdf_min    <= '0;
        end else begin
            // Read-return pipeline runs freely; it is empty whenever no reads were issued.
            rd_pend   <= hist_rd_en;
            rd_addr_d <= hist_addr;
            cdf_wr_en <= rd_pend;
            cdf_addr  <= rd_addr_d;
            cdf_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= SWEEP;
                        busy       <= 1'b1;
                        hist_rd_en <= 1'b1;
                        hist_addr  <= '0;
                        hist_bank  <= bank_sel;
                        cdf_bank   <= bank_sel;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (hist_addr == LAST_ADDR) begin
                        hist_rd_en <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        hist_addr <= hist_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // Last bin's data is being accumulated on this edge.
                    if (rd_pend && (rd_addr_d == LAST_ADDR)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    cdf_valid <= 1'b1;
                    cdf_min   <= acc_first_nz;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cdf_sequencer.md
CDF_SEQUENCER -- requirements
Module: cdf_sequencer

Interface
REQ-001 Parameter DATA_W, default 20, width of histogram bins, CDF values and cdf_min.
REQ-002 Parameter ADDR_W, default 8, bin address width.
REQ-003 Parameter BINS, default 256, number of histogram bins swept per run.
REQ-004 clock  in  1  single clock; all logic on its rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 start  in  1  request one CDF run; sampled only in IDLE.
REQ-007 bank_sel  in  1  ping-pong bank to process; latched at start acceptance.
REQ-008 hist_bank, cdf_bank  out  1 each  latched bank select driven to histogram and CDF memories.
REQ-009 hist_rd_en  out  1 / hist_addr  out  ADDR_W  histogram read request and address.
REQ-010 hist_rd_data  in  DATA_W  histogram read data, valid exactly one cycle after hist_rd_en.
REQ-011 cdf_wr_en  out  1 / cdf_addr  out  ADDR_W / cdf_wr_data  out  DATA_W  CDF memory write port.
REQ-012 cdf_min  out  DATA_W  first nonzero CDF value of the completed run.
REQ-013 cdf_valid  out  1  one-cycle pulse: cdf_min and CDF memory contents complete.
REQ-014 busy  out  1  high while a run is in progress.

Function
REQ-015 The FSM SHALL have states IDLE, SWEEP, DRAIN, DONE; IDLE->SWEEP on start, SWEEP->DRAIN after address BINS-1 is issued, DRAIN->DONE after the last CDF write, DONE->IDLE unconditionally after one cycle.
REQ-016 With start sampled high in IDLE at edge 0, hist_rd_en SHALL be high with hist_addr=k in cycle k+1, k=0..BINS-1, contiguous and ascending.
REQ-017 cdf_wr_en SHALL be high with cdf_addr=k and cdf_wr_data=CDF[k]=sum of bins 0..k in cycle k+3; all outputs are registered.
REQ-018 cdf_valid SHALL pulse for exactly one cycle, in cycle BINS+3 (259 at default); busy SHALL be high in cycles 1..BINS+3.
REQ-019 The accumulator SHALL saturate at 2^DATA_W-1 and never wrap; later CDF values stay saturated.
REQ-020 cdf_min SHALL capture the first nonzero CDF value; if all bins are zero, it SHALL be 0 and cdf_valid SHALL still pulse.
REQ-021 cdf_min SHALL hold its value from cdf_valid until the next run's cdf_valid, so it stays stable for the downstream divisor, FRAME_PIXELS - cdf_min.
REQ-022 start while busy SHALL be ignored; bank_sel changes after acceptance SHALL have no effect.
REQ-023 The accumulator and the min-found flag SHALL clear at start acceptance.

Reset
REQ-024 While reset_n is low at an edge, all outputs SHALL go to 0, cdf_min included, and the FSM SHALL go to IDLE.
REQ-025 Reset mid-run SHALL abort the run with no further memory accesses and no cdf_valid pulse; the next start SHALL run normally.

Configuration
REQ-026 Macro CDF_HIST_CLEAR_EN: when defined, the block SHALL add outputs hist_wr_en (1 bit) and hist_wr_addr (ADDR_W).
REQ-027 Under CDF_HIST_CLEAR_EN, zero SHALL be written to bin k in cycle k+2, so the bank is cleared for the next frame.
REQ-028 Without CDF_HIST_CLEAR_EN, those ports SHALL NOT exist and the histogram SHALL be read-only.

Structure
REQ-029 Shared package cdf_pkg SHALL hold the FSM state typedef, DATA_W, ADDR_W, BINS and FRAME_PIXELS=307200.
REQ-030 One sub-module, cdf_accum, SHALL implement the saturating add and first-nonzero capture; the FSM and address counter stay in cdf_sequencer.

Verification
REQ-031 Uniform histogram, 1200 per bin, bank_sel=1 -> CDF[k]=1200*(k+1), CDF[255]=307200, cdf_min=1200, hist_bank=cdf_bank=1, cdf_valid in cycle 259.
REQ-032 Bins 0..9=0, bin 10=5000, others 1 -> CDF[9]=0, CDF[10]=5000, cdf_min=5000.
REQ-033 All bins zero -> every CDF=0, cdf_min=0, single cdf_valid pulse.
REQ-034 Bins 0 and 1 = 0xFFFF0 -> CDF[1]=0xFFFFF and stays 0xFFFFF through bin 255.
REQ-035 reset_n low at cycle 100 -> all outputs 0 next cycle, no cdf_valid; then start -> full correct run.
REQ-036 Pulse start at cycle 50 and toggle bank_sel mid-run -> ignored, exactly one run and one cdf_valid; with CDF_HIST_CLEAR_EN, each bin reads 0 afterwards.
